// File: rtl/disparity_search_ctrl_if.sv
// Bundles the disparity search controller's external signals: start/busy, the line-buffer
// fetch port, the SSD engine operand/cost port and the result handshake.
//
// Modports:
//   master - the controller (drives busy, fetch request, mac operands, result)
//   slave  - the surrounding pipeline (drives start, fetch data, mac cost, result ready)
interface disparity_search_ctrl_if #(
    parameter int unsigned MAX_DISP   = 16,
    parameter int unsigned WIN_ROWS   = 6,
    parameter int unsigned ROW_COST_W = 20
);
    localparam int unsigned DISP_W = $clog2(MAX_DISP);
    localparam int unsigned ROW_W  = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1;
    localparam int unsigned ACC_W  = ROW_COST_W + $clog2(WIN_ROWS);
    localparam int unsigned PIX_W  = 48;

    logic                  start_in;
    logic                  busy_out;
    logic                  fetch_req_out;
    logic [DISP_W-1:0]     fetch_disp_out;
    logic [ROW_W-1:0]      fetch_row_out;
    logic                  fetch_valid_in;
    logic [PIX_W-1:0]      fetch_left_in;
    logic [PIX_W-1:0]      fetch_right_in;
    logic [PIX_W-1:0]      mac_left_out;
    logic [PIX_W-1:0]      mac_right_out;
    logic                  mac_valid_out;
    logic [ROW_COST_W-1:0] mac_cost_in;
    logic                  result_valid_out;
    logic                  result_ready_in;
    logic [DISP_W-1:0]     best_disp_out;
    logic [ACC_W-1:0]      best_cost_out;

    modport master (
        input  start_in, fetch_valid_in, fetch_left_in, fetch_right_in, mac_cost_in,
               result_ready_in,
        output busy_out, fetch_req_out, fetch_disp_out, fetch_row_out, mac_left_out,
               mac_right_out, mac_valid_out, result_valid_out, best_disp_out, best_cost_out
    );

    modport slave (
        output start_in, fetch_valid_in, fetch_left_in, fetch_right_in, mac_cost_in,
               result_ready_in,
        input  busy_out, fetch_req_out, fetch_disp_out, fetch_row_out, mac_left_out,
               mac_right_out, mac_valid_out, result_valid_out, best_disp_out, best_cost_out
    );
endinterface

// File: rtl/disparity_search_ctrl.sv
// Disparity search sequencer for one output pixel. Sweeps disparities 0..MAX_DISP-1, fetches
// WIN_ROWS left/right row pairs per disparity, hands each pair to the combinational SSD engine,
// sums the row costs and keeps the lowest-cost disparity (ties keep the lower disparity).
//
// Ports:
//   clk_in    - single clock, posedge
//   rst_n_in  - asynchronous active-low reset; aborts any search, all outputs return to 0
//   bus       - disparity_search_ctrl_if.master: start/busy, fetch port, SSD engine port,
//               result valid/ready handshake
//
// Optional feature: define DISP_SEARCH_EARLY_TERM_EN to abandon a disparity as soon as its
// running sum reaches the current best cost. Results are unchanged; only latency shrinks.
module disparity_search_ctrl #(
    parameter int unsigned MAX_DISP   = 16,
    parameter int unsigned WIN_ROWS   = 6,
    parameter int unsigned ROW_COST_W = 20
) (
    input logic                    clk_in,
    input logic                    rst_n_in,
    disparity_search_ctrl_if.master bus
);
    localparam int unsigned DISP_W = $clog2(MAX_DISP);
    localparam int unsigned ROW_W  = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1;
    localparam int unsigned ACC_W  = ROW_COST_W + $clog2(WIN_ROWS);
    localparam int unsigned PIX_W  = 48;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StAccum,
        StCompare,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [DISP_W-1:0] disp_q, disp_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  best_cost_q, best_cost_d;
    logic [DISP_W-1:0] best_disp_q, best_disp_d;
    logic              best_valid_q, best_valid_d;
    logic [PIX_W-1:0]  mac_left_q, mac_left_d;
    logic [PIX_W-1:0]  mac_right_q, mac_right_d;

    logic [ACC_W-1:0]  acc_sum;
    logic              last_row;
    logic              last_disp;
    logic              early_stop;

    assign acc_sum   = acc_q + ACC_W'(bus.mac_cost_in);
    assign last_row  = (row_q == ROW_W'(WIN_ROWS - 1));
    assign last_disp = (disp_q == DISP_W'(MAX_DISP - 1));

`ifdef DISP_SEARCH_EARLY_TERM_EN
    // Once the partial sum has reached the best cost this candidate can never win, so skip
    // the remaining rows; COMPARE then rejects it on the strict less-than test.
    assign early_stop = best_valid_q && (acc_sum >= best_cost_q);
`else
    assign early_stop = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        disp_d       = disp_q;
        row_d        = row_q;
        acc_d        = acc_q;
        best_cost_d  = best_cost_q;
        best_disp_d  = best_disp_q;
        best_valid_d = best_valid_q;
        mac_left_d   = mac_left_q;
        mac_right_d  = mac_right_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start_in) begin
                    disp_d       = '0;
                    row_d        = '0;
                    acc_d        = '0;
                    best_valid_d = 1'b0;
                    state_d      = StFetch;
                end
            end
            StFetch: begin
                if (bus.fetch_valid_in) begin
                    mac_left_d  = bus.fetch_left_in;
                    mac_right_d = bus.fetch_right_in;
                    state_d     = StAccum;
                end
            end
            StAccum: begin
                acc_d = acc_sum;
                if (last_row || early_stop) begin
                    state_d = StCompare;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = StFetch;
                end
            end
            StCompare: begin
                if (!best_valid_q || (acc_q < best_cost_q)) begin
                    best_cost_d  = acc_q;
                    best_disp_d  = disp_q;
                    best_valid_d = 1'b1;
                end
                acc_d = '0;
                row_d = '0;
                if (last_disp) begin
                    state_d = StDone;
                end else begin
                    disp_d  = disp_q + DISP_W'(1);
                    state_d = StFetch;
                end
            end
            StDone: begin
                if (bus.result_ready_in) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= StIdle;
            disp_q       <= '0;
            row_q        <= '0;
            acc_q        <= '0;
            best_cost_q  <= '0;
            best_disp_q  <= '0;
            best_valid_q <= 1'b0;
            mac_left_q   <= '0;
            mac_right_q  <= '0;
        end else begin
            state_q      <= state_d;
            disp_q       <= disp_d;
            row_q        <= row_d;
            acc_q        <= acc_d;
            best_cost_q  <= best_cost_d;
            best_disp_q  <= best_disp_d;
            best_valid_q <= best_valid_d;
            mac_left_q   <= mac_left_d;
            mac_right_q  <= mac_right_d;
        end
    end

    assign bus.busy_out         = (state_q != StIdle);
    assign bus.fetch_req_out    = (state_q == StFetch);
    assign bus.fetch_disp_out   = disp_q;
    assign bus.fetch_row_out    = row_q;
    assign bus.mac_left_out     = mac_left_q;
    assign bus.mac_right_out    = mac_right_q;
    assign bus.mac_valid_out    = (state_q == StAccum);
    assign bus.result_valid_out = (state_q == StDone);
    assign bus.best_disp_out    = best_disp_q;
    assign bus.best_cost_out    = best_cost_q;

endmodule

// File: tb/tb_disparity_search_ctrl.sv
module tb_disparity_search_ctrl;
    localparam int unsigned MAX_DISP = 16;
    localparam int unsigned WIN_ROWS = 6;

`ifdef DISP_SEARCH_EARLY_TERM_EN
    localparam int ExpD1Fetches = 1;
`else
    localparam int ExpD1Fetches = 6;
`endif

    typedef struct {
        int unsigned mode;      // 0: 100 except d=5 -> 10; 1: all 7; 2: d=0 -> 10, else 70
        int unsigned wait_cyc;  // fetch_valid delay after request
        int unsigned disp;
        int unsigned cost;
        int unsigned lat;       // result_valid cycle relative to start cycle
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    disparity_search_ctrl_if bus ();

    disparity_search_ctrl dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int unsigned mode = 0;
    int unsigned fetch_wait = 0;
    bit chk_seq = 1'b0;
    int ed = 0;
    int er = 0;
    int fetch_cnt [MAX_DISP];
    logic [95:0] mac_q [$];
    vec_t res_q [$];
    logic [19:0] cost_w;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SSD engine model: the cost is a function of the disparity tagged into the left row.
    always_comb begin
        cost_w = 20'd0;
        case (mode)
            0: cost_w = (bus.mac_left_out[15:8] == 8'd5) ? 20'd10 : 20'd100;
            1: cost_w = 20'd7;
            2: cost_w = (bus.mac_left_out[15:8] == 8'd0) ? 20'd10 : 20'd70;
            default: cost_w = 20'd0;
        endcase
    end
    assign bus.mac_cost_in = cost_w;

    // Line-buffer responder plus mac operand scoreboard.
    int wcnt = 0;
    int req_disp = 0;
    int req_row = 0;
    always @(posedge clk) begin
        logic [47:0] l;
        logic [47:0] r;
        logic [95:0] e;
        #1;
        if (!rst_n) begin
            bus.fetch_valid_in = 1'b0;
            wcnt = 0;
        end else begin
            if (bus.mac_valid_out) begin
                if (mac_q.size() == 0) begin
                    check("mac_valid without fetch", 1, 0);
                end else begin
                    e = mac_q.pop_front();
                    check("mac_left", bus.mac_left_out, e[95:48]);
                    check("mac_right", bus.mac_right_out, e[47:0]);
                end
            end
            bus.fetch_valid_in = 1'b0;
            if (bus.fetch_req_out) begin
                if (wcnt == 0) begin
                    req_disp = int'(bus.fetch_disp_out);
                    req_row  = int'(bus.fetch_row_out);
                    fetch_cnt[bus.fetch_disp_out]++;
                    if (chk_seq) begin
                        check("fetch_disp order", bus.fetch_disp_out, ed);
                        check("fetch_row order", bus.fetch_row_out, er);
                        er++;
                        if (er == WIN_ROWS) begin
                            er = 0;
                            ed++;
                        end
                    end
                end else begin
                    check("fetch_disp hold", bus.fetch_disp_out, req_disp);
                    check("fetch_row hold", bus.fetch_row_out, req_row);
                end
                if (wcnt == int'(fetch_wait)) begin
                    l = {$urandom(), 8'(req_disp), 8'(req_row)};
                    r = {16'($urandom()), $urandom()};
                    bus.fetch_left_in  = l;
                    bus.fetch_right_in = r;
                    bus.fetch_valid_in = 1'b1;
                    mac_q.push_back({l, r});
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " ctrl outs"}, {bus.busy_out, bus.fetch_req_out, bus.fetch_disp_out,
              bus.fetch_row_out, bus.mac_valid_out, bus.result_valid_out}, 0);
        check({tag, " mac_left"}, bus.mac_left_out, 0);
        check({tag, " mac_right"}, bus.mac_right_out, 0);
        check({tag, " best"}, {bus.best_disp_out, bus.best_cost_out}, 0);
    endtask

    // Raises start for one cycle; returns the cycle number T in which start was high.
    task automatic do_start(output int t0);
        for (int i = 0; i < MAX_DISP; i++) fetch_cnt[i] = 0;
        ed = 0;
        er = 0;
        @(posedge clk);
        #1;
        check("busy before start", bus.busy_out, 0);
        bus.start_in = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
        check("busy at T+1", bus.busy_out, 1);
        check("fetch_req at T+1", bus.fetch_req_out, 1);
        check("first fetch d/row", {bus.fetch_disp_out, bus.fetch_row_out}, 0);
    endtask

    task automatic wait_result(output bit ok);
        int n = 0;
        while (!bus.result_valid_out && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = bus.result_valid_out;
        if (!ok) check("result_valid timeout", 0, 1);
    endtask

    task automatic accept();
        bus.result_ready_in = 1'b1;
        @(posedge clk);
        #1;
        bus.result_ready_in = 1'b0;
        check("busy after accept", bus.busy_out, 0);
        check("result_valid after accept", bus.result_valid_out, 0);
    endtask

    task automatic recover();
        rst_n = 1'b0;
        mac_q.delete();
        res_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int t0;
        bit ok;
        vec_t e;
        mode = v.mode;
        fetch_wait = v.wait_cyc;
        res_q.push_back(v);
        do_start(t0);
        wait_result(ok);
        if (ok) begin
`ifndef DISP_SEARCH_EARLY_TERM_EN
            check("result latency", cyc - t0, v.lat);
`endif
            e = res_q.pop_front();
            check("best_disp", bus.best_disp_out, e.disp);
            check("best_cost", bus.best_cost_out, e.cost);
            accept();
        end else begin
            recover();
        end
    endtask

    vec_t vecs [5];

    initial begin
        int t0;
        int n;
        bit ok;

        vecs[0] = '{mode: 0, wait_cyc: 0, disp: 5, cost: 60, lat: 209};
        vecs[1] = '{mode: 1, wait_cyc: 0, disp: 0, cost: 42, lat: 209};
        vecs[2] = '{mode: 0, wait_cyc: 3, disp: 5, cost: 60, lat: 497};
        vecs[3] = '{mode: 1, wait_cyc: 1, disp: 0, cost: 42, lat: 305};
        vecs[4] = '{mode: 2, wait_cyc: 0, disp: 0, cost: 60, lat: 209};

`ifdef DISP_SEARCH_EARLY_TERM_EN
        chk_seq = 1'b0;
`else
        chk_seq = 1'b1;
`endif
        bus.start_in        = 1'b0;
        bus.result_ready_in = 1'b0;
        bus.fetch_valid_in  = 1'b0;
        bus.fetch_left_in   = '0;
        bus.fetch_right_in  = '0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // DONE holds while result_ready is low; a start pulse there is ignored.
        mode = 1;
        fetch_wait = 0;
        do_start(t0);
        wait_result(ok);
        if (ok) begin
            for (int i = 0; i < 10; i++) begin
                bus.start_in = (i == 3);
                @(posedge clk);
                #1;
                check("hold result_valid", bus.result_valid_out, 1);
                check("hold busy", bus.busy_out, 1);
                check("hold best", {bus.best_disp_out, bus.best_cost_out}, {4'd0, 23'd42});
                check("hold no fetch", bus.fetch_req_out, 0);
            end
            bus.start_in = 1'b0;
            accept();
            check("no restart from ignored start", bus.fetch_req_out, 0);
        end else begin
            recover();
        end

        // Asynchronous reset in the middle of d=7, row=3.
        mode = 0;
        do_start(t0);
        n = 0;
        while (!(bus.fetch_req_out && bus.fetch_disp_out == 4'd7 && bus.fetch_row_out == 3'd3)
               && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached d7 row3", {bus.fetch_disp_out, bus.fetch_row_out}, {4'd7, 3'd3});
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        mac_q.delete();
        bus.fetch_valid_in = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("reset held");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_vec(vecs[0]);

        // Candidate that is already worse after its first row.
        mode = 2;
        fetch_wait = 0;
        do_start(t0);
        wait_result(ok);
        if (ok) begin
            check("fetches d0", fetch_cnt[0], 6);
            check("fetches d1", fetch_cnt[1], ExpD1Fetches);
            check("early best_disp", bus.best_disp_out, 0);
            check("early best_cost", bus.best_cost_out, 60);
            accept();
        end else begin
            recover();
        end

        check("mac scoreboard drained", mac_q.size(), 0);
        check("result scoreboard drained", res_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
